// File: rtl/atm_keypad_if.sv
// Panel/controller signal bundle for the ATM keypad front end.
// master = the front end itself, slave = controller/panel side.
interface atm_keypad_if;
  logic        card_in;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        pin_incorrecto;
  logic        advertencia;
  logic        bloqueo;
  logic        entregar_dinero;
  logic        fondos_insuficientes;
  logic        balance_actualizado;
  logic        tarjeta_recibida;
  logic [3:0]  digito;
  logic        digito_stb;
  logic        tipo_trans;
  logic [31:0] monto;
  logic        monto_stb;
  logic [2:0]  status;

  modport master (
    input  card_in, key_code, key_valid, pin_incorrecto, advertencia, bloqueo,
           entregar_dinero, fondos_insuficientes, balance_actualizado,
    output tarjeta_recibida, digito, digito_stb, tipo_trans, monto, monto_stb, status
  );

  modport slave (
    output card_in, key_code, key_valid, pin_incorrecto, advertencia, bloqueo,
           entregar_dinero, fondos_insuficientes, balance_actualizado,
    input  tarjeta_recibida, digito, digito_stb, tipo_trans, monto, monto_stb, status
  );
endinterface

// File: rtl/atm_keypad_frontend.sv
// Turns card-reader and keypad events into ATM controller handshake signals
// and folds the controller's result flags into a 3-bit display status.
module atm_keypad_frontend #(
  parameter int PIN_DIGITS      = 4,
  parameter int AMT_DIGITS      = 9,
  parameter int PIN_WAIT_CYCLES = 8,
  parameter int RESP_TIMEOUT    = 16
) (
  input  logic         clk,
  input  logic         reset,
  atm_keypad_if.master bus
);
  localparam int PW = $clog2(PIN_DIGITS + 1);
  localparam int AW = $clog2(AMT_DIGITS + 1);
  localparam int TMAX = (PIN_WAIT_CYCLES > RESP_TIMEOUT) ? PIN_WAIT_CYCLES : RESP_TIMEOUT;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [PW-1:0] PIN_LAST = PW'(PIN_DIGITS - 1);
  localparam logic [AW-1:0] AMT_MAX  = AW'(AMT_DIGITS);
  localparam logic [TW-1:0] PIN_TMO  = TW'(PIN_WAIT_CYCLES);
  localparam logic [TW-1:0] RESP_TMO = TW'(RESP_TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, SELECT, PIN, PIN_WAIT, AMOUNT, AMT_WAIT, DONE, EJECT, LOCKED
  } state_t;

  state_t        state_q, state_n;
  logic          tarj_q, tarj_n, dstb_q, dstb_n, tipo_q, tipo_n, mstb_q, mstb_n;
  logic [3:0]    digito_q, digito_n;
  logic [31:0]   monto_q, monto_n, acc_q, acc_n;
  logic [2:0]    status_q, status_n;
  logic [PW-1:0] pcnt_q, pcnt_n;
  logic [AW-1:0] acnt_q, acnt_n;
  logic [TW-1:0] tmr_q, tmr_n;
  logic          is_digit, is_cancel, is_enter, is_clear;
  logic [35:0]   mac;

  assign is_digit  = bus.key_valid && (bus.key_code < 4'd10);
  assign is_cancel = bus.key_valid && (bus.key_code == 4'hB);
  assign is_enter  = bus.key_valid && (bus.key_code == 4'hA);
  assign is_clear  = bus.key_valid && (bus.key_code == 4'hE);
  // acc*10 + d via shifts, widened so the intermediate cannot wrap
  assign mac = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) + {32'b0, bus.key_code};

  always_comb begin
    state_n  = state_q;
    tarj_n   = tarj_q;
    digito_n = digito_q;
    dstb_n   = 1'b0;
    tipo_n   = tipo_q;
    monto_n  = monto_q;
    mstb_n   = 1'b0;
    status_n = status_q;
    pcnt_n   = pcnt_q;
    acnt_n   = acnt_q;
    acc_n    = acc_q;
    tmr_n    = tmr_q;
    if (state_q != LOCKED && !bus.card_in) begin
      // card removal wins over any key in the same cycle
      state_n  = IDLE;
      tarj_n   = 1'b0;
      digito_n = 4'd0;
      tipo_n   = 1'b0;
      monto_n  = 32'd0;
      status_n = 3'd0;
      pcnt_n   = '0;
      acnt_n   = '0;
      acc_n    = 32'd0;
      tmr_n    = '0;
    end else if (is_cancel && (state_q == SELECT || state_q == PIN || state_q == PIN_WAIT ||
                               state_q == AMOUNT || state_q == AMT_WAIT)) begin
      state_n  = EJECT;
      tarj_n   = 1'b0;
      status_n = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_n  = SELECT;
          status_n = 3'd1;
        end
        SELECT: begin
          if (bus.key_valid && (bus.key_code == 4'hC || bus.key_code == 4'hD)) begin
            tipo_n   = (bus.key_code == 4'hC);
            tarj_n   = 1'b1;
            status_n = 3'd2;
            pcnt_n   = '0;
            state_n  = PIN;
          end
        end
        PIN: begin
          if (is_digit) begin
            digito_n = bus.key_code;
            dstb_n   = 1'b1;
            pcnt_n   = pcnt_q + 1'b1;
            if (pcnt_q == PIN_LAST) begin
              state_n = PIN_WAIT;
              tmr_n   = '0;
            end
          end
        end
        PIN_WAIT: begin
          if (bus.advertencia) status_n = 3'd2;
          if (bus.bloqueo) begin
            state_n  = LOCKED;
            tarj_n   = 1'b0;
            status_n = 3'd6;
          end else if (bus.pin_incorrecto) begin
            state_n = PIN;
            pcnt_n  = '0;
          end else begin
            tmr_n = tmr_q + 1'b1;
            if (tmr_n == PIN_TMO) begin
              state_n  = AMOUNT;
              status_n = 3'd3;
              acc_n    = 32'd0;
              acnt_n   = '0;
            end
          end
        end
        AMOUNT: begin
          if (is_digit) begin
            if (acnt_q < AMT_MAX) begin
              acc_n  = mac[31:0];
              acnt_n = acnt_q + 1'b1;
            end
          end else if (is_clear) begin
            acc_n  = 32'd0;
            acnt_n = '0;
          end else if (is_enter && acnt_q != '0) begin
            monto_n = acc_q;
            mstb_n  = 1'b1;
            tmr_n   = '0;
            state_n = AMT_WAIT;
          end
        end
        AMT_WAIT: begin
          if (bus.fondos_insuficientes) begin
            status_n = 3'd5;
            state_n  = DONE;
          end else if (bus.entregar_dinero || bus.balance_actualizado) begin
            status_n = 3'd4;
            state_n  = DONE;
          end else begin
            tmr_n = tmr_q + 1'b1;
            if (tmr_n == RESP_TMO) begin
              status_n = 3'd7;
              state_n  = DONE;
            end
          end
        end
        default: ;  // DONE, EJECT: only card removal leaves; LOCKED: only reset leaves
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tarj_q   <= 1'b0;
      digito_q <= 4'd0;
      dstb_q   <= 1'b0;
      tipo_q   <= 1'b0;
      monto_q  <= 32'd0;
      mstb_q   <= 1'b0;
      status_q <= 3'd0;
      pcnt_q   <= '0;
      acnt_q   <= '0;
      acc_q    <= 32'd0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_n;
      tarj_q   <= tarj_n;
      digito_q <= digito_n;
      dstb_q   <= dstb_n;
      tipo_q   <= tipo_n;
      monto_q  <= monto_n;
      mstb_q   <= mstb_n;
      status_q <= status_n;
      pcnt_q   <= pcnt_n;
      acnt_q   <= acnt_n;
      acc_q    <= acc_n;
      tmr_q    <= tmr_n;
    end
  end

  assign bus.tarjeta_recibida = tarj_q;
  assign bus.digito           = digito_q;
  assign bus.digito_stb       = dstb_q;
  assign bus.tipo_trans       = tipo_q;
  assign bus.monto            = monto_q;
  assign bus.monto_stb        = mstb_q;
  assign bus.status           = status_q;
endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Scoreboard bench: expected digit/amount strobes are queued as keys are driven
// and popped by a monitor whenever the front end strobes.
module tb_atm_keypad_frontend;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [3:0]  dig_q[$];
  logic [31:0] amt_q[$];

  atm_keypad_if bus();
  atm_keypad_frontend dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input logic [3:0] code);
    @(negedge clk);
    bus.key_code  = code;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic pin_key(input logic [3:0] d);
    dig_q.push_back(d);
    key(d);
  endtask

  // flag bits: {fondos, entregar, balance, bloqueo, pin_incorrecto, advertencia}
  task automatic pulse(input logic [5:0] f);
    @(negedge clk);
    {bus.fondos_insuficientes, bus.entregar_dinero, bus.balance_actualizado,
     bus.bloqueo, bus.pin_incorrecto, bus.advertencia} = f;
    @(negedge clk);
    {bus.fondos_insuficientes, bus.entregar_dinero, bus.balance_actualizado,
     bus.bloqueo, bus.pin_incorrecto, bus.advertencia} = 6'b0;
  endtask

  task automatic start_session(input logic [3:0] type_key);
    @(negedge clk);
    bus.card_in = 1'b1;
    step(1);
    key(type_key);
    for (int i = 1; i <= 4; i++) pin_key(4'(i));
    step(8);
  endtask

  always @(negedge clk) begin
    if (bus.digito_stb) begin
      if (dig_q.size() == 0) chk("unexpected_digito_stb", 1, 0);
      else chk("digito", bus.digito, dig_q.pop_front());
    end
    if (bus.monto_stb) begin
      if (amt_q.size() == 0) chk("unexpected_monto_stb", 1, 0);
      else chk("monto", bus.monto, amt_q.pop_front());
    end
  end

  initial begin
    reset = 1'b1;
    bus.card_in = 1'b0; bus.key_code = 4'h0; bus.key_valid = 1'b0;
    bus.pin_incorrecto = 1'b0; bus.advertencia = 1'b0; bus.bloqueo = 1'b0;
    bus.entregar_dinero = 1'b0; bus.fondos_insuficientes = 1'b0; bus.balance_actualizado = 1'b0;
    step(3);
    chk("rst_status", bus.status, 0);
    chk("rst_tarjeta", bus.tarjeta_recibida, 0);
    chk("rst_monto", bus.monto, 0);
    chk("rst_strobes", {bus.digito_stb, bus.monto_stb, bus.tipo_trans}, 0);
    reset = 1'b0;

    // withdrawal, PIN wait boundary, amount 500, no funds wins over dispense
    @(negedge clk); bus.card_in = 1'b1;
    step(1);
    chk("select_status", bus.status, 1);
    chk("select_tarjeta", bus.tarjeta_recibida, 0);
    key(4'hC);
    chk("tipo_withdraw", bus.tipo_trans, 1);
    chk("pin_tarjeta", bus.tarjeta_recibida, 1);
    chk("pin_status", bus.status, 2);
    for (int i = 1; i <= 4; i++) pin_key(4'(i));
    step(7);
    chk("pinwait_7", bus.status, 2);
    step(1);
    chk("pinwait_8", bus.status, 3);
    key(4'd5); key(4'd0); key(4'd0);
    amt_q.push_back(32'd500);
    key(4'hA);
    step(1);
    chk("monto_stb_1cyc", bus.monto_stb, 0);
    chk("monto_held", bus.monto, 500);
    pulse(6'b110000);
    chk("no_funds", bus.status, 5);
    @(negedge clk); bus.card_in = 1'b0;
    step(1);
    chk("out_status", bus.status, 0);
    chk("out_tarjeta", bus.tarjeta_recibida, 0);
    chk("out_monto", bus.monto, 0);
    chk("out_misc", {bus.tipo_trans, bus.digito}, 0);

    // deposit, two wrong PINs, warning, then block
    @(negedge clk); bus.card_in = 1'b1;
    step(1);
    key(4'hD);
    chk("tipo_deposit", bus.tipo_trans, 0);
    for (int a = 0; a < 2; a++) begin
      for (int i = 0; i < 4; i++) pin_key(4'd7);
      pulse(6'b000010);
      chk("retry_status", bus.status, 2);
    end
    for (int i = 0; i < 4; i++) pin_key(4'd3);
    pulse(6'b000001);
    chk("warn_status", bus.status, 2);
    pulse(6'b000100);
    chk("locked_status", bus.status, 6);
    chk("locked_tarjeta", bus.tarjeta_recibida, 0);
    key(4'd5); key(4'hC);
    @(negedge clk); bus.card_in = 1'b0;
    step(2);
    chk("locked_hold", bus.status, 6);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("unlock_status", bus.status, 0);

    // ten nines saturate at nine digits; no response -> timeout
    start_session(4'hC);
    for (int i = 0; i < 10; i++) key(4'd9);
    amt_q.push_back(32'd999_999_999);
    key(4'hA);
    step(15);
    chk("tmo_15", bus.status, 3);
    step(1);
    chk("tmo_16", bus.status, 7);
    @(negedge clk); bus.card_in = 1'b0;
    step(1);

    // clear then enter is ignored; clear really zeroes the accumulator
    start_session(4'hC);
    key(4'd3); key(4'hE); key(4'hA);
    step(2);
    chk("clear_status", bus.status, 3);
    amt_q.push_back(32'd7);
    key(4'd7); key(4'hA);
    pulse(6'b010000);
    chk("done_ok", bus.status, 4);
    @(negedge clk); bus.card_in = 1'b0;
    step(1);

    // cancel during amount entry
    start_session(4'hD);
    key(4'd2);
    key(4'hB);
    chk("cancel_tarjeta", bus.tarjeta_recibida, 0);
    @(negedge clk); bus.card_in = 1'b0;
    step(1);

    // reset in the middle of the PIN
    @(negedge clk); bus.card_in = 1'b1;
    step(1);
    key(4'hC);
    pin_key(4'd1); pin_key(4'd2);
    reset = 1'b1;
    step(1);
    chk("midrst_outs", {bus.tarjeta_recibida, bus.tipo_trans, bus.digito_stb, bus.digito, bus.status}, 0);
    reset = 1'b0;
    bus.card_in = 1'b0;
    step(2);

    chk("digits_left", dig_q.size(), 0);
    chk("amounts_left", amt_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
